hpi_cycle_ctrl: RTL and testbench
=================================

HPI_CYCLE_CTRL -- requirements
Module: hpi_cycle_ctrl

Interface
REQ-001 Parameter SETUP_CYC, default 1: cycles with CS_N low and address/data stable before the strobe.
REQ-002 Parameter STROBE_CYC, default 4: cycles with RD_N or WR_N low.
REQ-003 Parameter HOLD_CYC, default 2: cycles after the strobe with CS_N low and address/data held.
REQ-004 clk  in  1  single clock; every register is clocked on its rising edge.
REQ-005 reset_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-006 address  in  2  Avalon-MM slave word address; maps to the HPI register select.
REQ-007 chipselect  in  1  Avalon slave select.
REQ-008 read  in  1  Avalon read request.
REQ-009 write  in  1  Avalon write request.
REQ-010 writedata  in  16  Avalon write data.
REQ-011 readdata  out  16  data captured from the HPI read.
REQ-012 waitrequest  out  1  Avalon stall.
REQ-013 otg_addr  out  2  HPI address.
REQ-014 otg_data_out  out  16  HPI write data.
REQ-015 otg_data_oe  out  1  tristate enable for HPI data, active-high.
REQ-016 otg_data_in  in  16  HPI read data.
REQ-017 otg_cs_n, otg_rd_n, otg_wr_n  out  1 each  HPI strobes, active-low.

Function
REQ-018 A request is valid when chipselect=1 and (read=1 or write=1).
- If read and write are both 1, the request is a write.
REQ-019 FSM states: IDLE, SETUP, STROBE, HOLD, DONE.
REQ-020 IDLE:
- A valid request latches address, direction and writedata.
- Next state is SETUP.
- With no valid request, stay in IDLE.
REQ-021 SETUP lasts SETUP_CYC cycles, then STROBE.
- otg_cs_n=0; otg_addr driven from the latch.
- For writes: otg_data_oe=1, otg_data_out driven from the latch.
REQ-022 STROBE lasts STROBE_CYC cycles, then HOLD.
- otg_rd_n=0 for reads; otg_wr_n=0 for writes.
- For reads, otg_data_in is registered into readdata on the last STROBE cycle.
REQ-023 HOLD lasts HOLD_CYC cycles, then DONE.
- otg_rd_n=otg_wr_n=1; otg_cs_n, otg_addr, otg_data_out and otg_data_oe are unchanged.
REQ-024 DONE lasts exactly 1 cycle, then IDLE.
- otg_cs_n=1, otg_data_oe=0, waitrequest=0.
- readdata is valid and is held until the next read capture.
REQ-025 waitrequest = (valid request) AND (state != DONE); it is a combinational output of the registered state.
REQ-026 Latency: with the request first valid in cycle 0, waitrequest is low in cycle SETUP_CYC+STROBE_CYC+HOLD_CYC+1 (cycle 8 with defaults).
REQ-027 Between accesses, otg_cs_n is high for at least 2 cycles (DONE plus IDLE), including back-to-back requests.
REQ-028 A request withdrawn mid-transaction does not abort the HPI cycle; the FSM completes and returns to IDLE.
REQ-029 A request still asserted in the IDLE cycle after DONE starts a new transaction.
REQ-030 otg_rd_n and otg_wr_n are never both low in any cycle.
REQ-031 Phase timer: 4 bits wide; each parameter is limited to 1..15, enforced at elaboration.

Reset
REQ-032 While reset_n=0 at a clock edge, the block enters IDLE.
- Outputs: readdata=0, otg_cs_n=otg_rd_n=otg_wr_n=1, otg_data_oe=0, otg_addr=0, otg_data_out=0; the timer is cleared.
REQ-033 Reset asserted mid-transaction deasserts all strobes at that same edge; no transaction resumes afterwards.

Structure
REQ-034 Package hpi_pkg holds:
- the state enum;
- default timing constants;
- HPI register address constants: DATA=0, MAILBOX=1, ADDR=2, STATUS=3.
REQ-035 One sub-module, hpi_phase_timer: a loadable 4-bit down-counter with a terminal-count output, used by SETUP, STROBE and HOLD.

Verification
REQ-036 Write address=2, writedata=0x1234 with default parameters:
- otg_cs_n low for 7 cycles and otg_wr_n low for 4 cycles;
- otg_data_out=0x1234 with oe=1 throughout;
- waitrequest low in cycle 8.
REQ-037 Read address=0 with otg_data_in=0xBEEF during STROBE:
- readdata=0xBEEF in DONE;
- otg_rd_n low for 4 cycles; otg_data_oe stays 0.
REQ-038 Two back-to-back writes (request held): otg_cs_n high for exactly 2 cycles between them; the second completes in cycle 17.
REQ-039 reset_n pulled low in the 2nd STROBE cycle: all strobes high and oe=0 after that edge; FSM in IDLE; readdata=0.
REQ-040 read=write=1 at address 1: a write cycle executes and otg_rd_n never goes low.
REQ-041 With SETUP_CYC=15, STROBE_CYC=1, HOLD_CYC=15: phase lengths match exactly; waitrequest low in cycle 32.

Source files
------------

// File: rtl/hpi_pkg.sv
// Shared types and constants for the HPI cycle controller.
package hpi_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam int DEF_SETUP_CYC  = 1;
  localparam int DEF_STROBE_CYC = 4;
  localparam int DEF_HOLD_CYC   = 2;
  localparam int MAX_PHASE_CYC  = 15;

  localparam logic [1:0] HPI_DATA    = 2'd0;
  localparam logic [1:0] HPI_MAILBOX = 2'd1;
  localparam logic [1:0] HPI_ADDR    = 2'd2;
  localparam logic [1:0] HPI_STATUS  = 2'd3;

endpackage

// File: rtl/hpi_phase_timer.sv
// Loadable 4-bit down-counter; tc is high once the count reaches zero.
module hpi_phase_timer (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       tc
);

  logic [3:0] count;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_val;
    end else if (count != 4'd0) begin
      count <= count - 4'd1;
    end
  end

  assign tc = (count == 4'd0);

endmodule

// File: rtl/hpi_cycle_ctrl.sv
// Avalon-MM slave to HPI bus bridge: sequences setup, strobe and
// hold phases around each access, then signals completion.
module hpi_cycle_ctrl
  import hpi_pkg::*;
#(
  parameter int SETUP_CYC  = DEF_SETUP_CYC,
  parameter int STROBE_CYC = DEF_STROBE_CYC,
  parameter int HOLD_CYC   = DEF_HOLD_CYC
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        waitrequest,
  output logic [1:0]  otg_addr,
  output logic [15:0] otg_data_out,
  output logic        otg_data_oe,
  input  logic [15:0] otg_data_in,
  output logic        otg_cs_n,
  output logic        otg_rd_n,
  output logic        otg_wr_n
);

  if (SETUP_CYC < 1 || SETUP_CYC > MAX_PHASE_CYC ||
      STROBE_CYC < 1 || STROBE_CYC > MAX_PHASE_CYC ||
      HOLD_CYC < 1 || HOLD_CYC > MAX_PHASE_CYC) begin : g_bad_timing
    $error("hpi_cycle_ctrl: phase lengths must be 1..15");
  end

  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

  state_t      state;
  state_t      state_nx;
  logic        req;
  logic        is_wr;
  logic [1:0]  addr_q;
  logic [15:0] wdata_q;
  logic        ld;
  logic [3:0]  ld_val;
  logic        tc;
  logic        active;

  assign req = chipselect & (read | write);

  hpi_phase_timer u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (ld),
    .load_val (ld_val),
    .tc       (tc)
  );

  always_comb begin
    state_nx = state;
    ld       = 1'b0;
    ld_val   = 4'd0;
    unique case (state)
      IDLE: begin
        if (req) begin
          state_nx = SETUP;
          ld       = 1'b1;
          ld_val   = SETUP_LD;
        end
      end
      SETUP: begin
        if (tc) begin
          state_nx = STROBE;
          ld       = 1'b1;
          ld_val   = STROBE_LD;
        end
      end
      STROBE: begin
        if (tc) begin
          state_nx = HOLD;
          ld       = 1'b1;
          ld_val   = HOLD_LD;
        end
      end
      HOLD: begin
        if (tc) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      is_wr    <= 1'b0;
      addr_q   <= 2'd0;
      wdata_q  <= 16'd0;
      readdata <= 16'd0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req) begin
        is_wr   <= write;
        addr_q  <= address;
        wdata_q <= writedata;
      end
      if (state == STROBE && tc && !is_wr) begin
        readdata <= otg_data_in;
      end
    end
  end

  // Strobes decode straight from the registered state so a reset
  // edge drops them immediately.
  assign active = (state == SETUP) | (state == STROBE) | (state == HOLD);

  assign otg_cs_n     = ~active;
  assign otg_data_oe  = active & is_wr;
  assign otg_rd_n     = ~((state == STROBE) & ~is_wr);
  assign otg_wr_n     = ~((state == STROBE) & is_wr);
  assign otg_addr     = addr_q;
  assign otg_data_out = wdata_q;
  assign waitrequest  = req & (state != DONE);

endmodule

// File: tb/tb_hpi_cycle_ctrl.sv
// Directed bench for hpi_cycle_ctrl: per-cycle vector table plus
// hand-written multi-cycle sequences.
module tb_hpi_cycle_ctrl;
  import hpi_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect, read, write;
  logic [15:0] writedata, data_in;
  logic [15:0] readdata;
  logic        waitrequest;
  logic [1:0]  otg_addr;
  logic [15:0] otg_data_out;
  logic        otg_data_oe, otg_cs_n, otg_rd_n, otg_wr_n;

  logic        cs2, rd2, wr2;
  logic [15:0] readdata2;
  logic        wait2;
  logic [1:0]  addr2;
  logic [15:0] dout2;
  logic        oe2, cs_n2, rd_n2, wr_n2;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  hpi_cycle_ctrl dut (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata),
    .waitrequest(waitrequest), .otg_addr(otg_addr),
    .otg_data_out(otg_data_out), .otg_data_oe(otg_data_oe),
    .otg_data_in(data_in), .otg_cs_n(otg_cs_n),
    .otg_rd_n(otg_rd_n), .otg_wr_n(otg_wr_n)
  );

  hpi_cycle_ctrl #(.SETUP_CYC(15), .STROBE_CYC(1), .HOLD_CYC(15)) dut2 (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(cs2), .read(rd2), .write(wr2),
    .writedata(writedata), .readdata(readdata2),
    .waitrequest(wait2), .otg_addr(addr2),
    .otg_data_out(dout2), .otg_data_oe(oe2),
    .otg_data_in(data_in), .otg_cs_n(cs_n2),
    .otg_rd_n(rd_n2), .otg_wr_n(wr_n2)
  );

  typedef struct {
    logic        cs, rd, wr;
    logic [1:0]  a;
    logic [15:0] wd, din;
    logic        wreq, cs_n, rd_n, wr_n, oe;
    logic [15:0] rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic cs, logic rd, logic wr, logic [1:0] a,
                              logic [15:0] wd, logic [15:0] din,
                              logic wreq, logic cs_n, logic rd_n,
                              logic wr_n, logic oe, logic [15:0] rdata);
    vec_t v;
    v.cs = cs; v.rd = rd; v.wr = wr; v.a = a; v.wd = wd; v.din = din;
    v.wreq = wreq; v.cs_n = cs_n; v.rd_n = rd_n; v.wr_n = wr_n;
    v.oe = oe; v.rdata = rdata;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(logic cs, logic rd, logic wr, logic [1:0] a,
                       logic [15:0] wd);
    chipselect = cs; read = rd; write = wr; address = a; writedata = wd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c, first, second, hi, lo_rd, lo_wr, lo_cs, oe_hi, first_wr, last_wr;
    reset_n = 1'b0;
    drive(0, 0, 0, 2'd0, 16'h0);
    data_in = 16'h0;
    cs2 = 0; rd2 = 0; wr2 = 0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("rst_cs_n", otg_cs_n, 1);
    chk("rst_rd_n", otg_rd_n, 1);
    chk("rst_wr_n", otg_wr_n, 1);
    chk("rst_oe", otg_data_oe, 0);
    chk("rst_addr", otg_addr, 0);
    chk("rst_dout", otg_data_out, 0);
    chk("rst_rdata", readdata, 0);
    next_cycle();
    reset_n = 1'b1;

    // write addr 2 / 0x1234, cycles 0..9
    vecs.push_back(mk(1,0,1,HPI_ADDR,16'h1234,0, 1,1,1,1,0, 0));
    vecs.push_back(mk(1,0,1,HPI_ADDR,16'h1234,0, 1,0,1,1,1, 0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1,0,1,HPI_ADDR,16'h1234,0, 1,0,1,0,1, 0));
    for (int i = 0; i < 2; i++)
      vecs.push_back(mk(1,0,1,HPI_ADDR,16'h1234,0, 1,0,1,1,1, 0));
    vecs.push_back(mk(1,0,1,HPI_ADDR,16'h1234,0, 0,1,1,1,0, 0));
    vecs.push_back(mk(0,0,0,HPI_ADDR,16'h1234,0, 0,1,1,1,0, 0));
    // read addr 0, 0xBEEF presented only during strobe
    vecs.push_back(mk(1,1,0,HPI_DATA,0,16'h0F0F, 1,1,1,1,0, 0));
    vecs.push_back(mk(1,1,0,HPI_DATA,0,16'h0F0F, 1,0,1,1,0, 0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1,1,0,HPI_DATA,0,16'hBEEF, 1,0,0,1,0, 0));
    for (int i = 0; i < 2; i++)
      vecs.push_back(mk(1,1,0,HPI_DATA,0,16'h0F0F, 1,0,1,1,0, 16'hBEEF));
    vecs.push_back(mk(1,1,0,HPI_DATA,0,16'h0F0F, 0,1,1,1,0, 16'hBEEF));
    vecs.push_back(mk(0,0,0,HPI_DATA,0,16'h0F0F, 0,1,1,1,0, 16'hBEEF));

    foreach (vecs[i]) begin
      drive(vecs[i].cs, vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].wd);
      data_in = vecs[i].din;
      @(negedge clk);
      chk($sformatf("v%0d_wait", i), waitrequest, vecs[i].wreq);
      chk($sformatf("v%0d_cs_n", i), otg_cs_n, vecs[i].cs_n);
      chk($sformatf("v%0d_rd_n", i), otg_rd_n, vecs[i].rd_n);
      chk($sformatf("v%0d_wr_n", i), otg_wr_n, vecs[i].wr_n);
      chk($sformatf("v%0d_oe", i), otg_data_oe, vecs[i].oe);
      chk($sformatf("v%0d_rdata", i), readdata, vecs[i].rdata);
      if (!vecs[i].cs_n)
        chk($sformatf("v%0d_addr", i), otg_addr, vecs[i].a);
      if (vecs[i].oe)
        chk($sformatf("v%0d_dout", i), otg_data_out, vecs[i].wd);
      next_cycle();
    end

    // back-to-back writes, request held throughout
    first = -1; second = -1; hi = 0;
    drive(1, 0, 1, HPI_STATUS, 16'hA5A5);
    for (c = 0; c < 18; c++) begin
      @(negedge clk);
      if (!waitrequest && first < 0) first = c;
      else if (!waitrequest && second < 0) second = c;
      if (c > 0 && c < 17 && otg_cs_n) hi++;
      next_cycle();
    end
    drive(0, 0, 0, 2'd0, 16'h0);
    chk("b2b_first_done", first, 8);
    chk("b2b_second_done", second, 17);
    chk("b2b_cs_high_gap", hi, 2);
    next_cycle();

    // read and write both set: must run as a write
    lo_rd = 0; lo_wr = 0; first = -1;
    drive(1, 1, 1, HPI_MAILBOX, 16'h5A5A);
    for (c = 0; c < 9; c++) begin
      @(negedge clk);
      if (!otg_rd_n) lo_rd++;
      if (!otg_wr_n) lo_wr++;
      if (!otg_cs_n && otg_addr != HPI_MAILBOX) lo_rd += 100;
      if (!waitrequest && first < 0) first = c;
      next_cycle();
    end
    drive(0, 0, 0, 2'd0, 16'h0);
    chk("rw_rd_low", lo_rd, 0);
    chk("rw_wr_low", lo_wr, 4);
    chk("rw_done", first, 8);
    next_cycle();

    // request withdrawn after two cycles: cycle still completes
    lo_cs = 0; lo_wr = 0; hi = 0;
    for (c = 0; c < 11; c++) begin
      if (c < 2) drive(1, 0, 1, HPI_ADDR, 16'h0042);
      else drive(0, 0, 0, 2'd0, 16'h0);
      @(negedge clk);
      if (!otg_cs_n) lo_cs++;
      if (!otg_wr_n) lo_wr++;
      if (c >= 8 && otg_cs_n) hi++;
      next_cycle();
    end
    chk("wd_cs_low", lo_cs, 7);
    chk("wd_wr_low", lo_wr, 4);
    chk("wd_idle_after", hi, 3);

    // reset in the 2nd strobe cycle of a write
    drive(1, 0, 1, HPI_ADDR, 16'h7777);
    for (c = 0; c < 3; c++) next_cycle();
    reset_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_wr_low_before", otg_wr_n, 0);
    next_cycle();
    reset_n = 1'b1;
    drive(0, 0, 0, 2'd0, 16'h0);
    @(negedge clk);
    chk("rst_mid_cs_n", otg_cs_n, 1);
    chk("rst_mid_wr_n", otg_wr_n, 1);
    chk("rst_mid_rd_n", otg_rd_n, 1);
    chk("rst_mid_oe", otg_data_oe, 0);
    chk("rst_mid_rdata", readdata, 0);
    hi = 0;
    for (c = 0; c < 6; c++) begin
      next_cycle();
      @(negedge clk);
      if (otg_cs_n) hi++;
    end
    chk("rst_mid_no_resume", hi, 6);
    next_cycle();

    // fresh read after reset starts cleanly from IDLE
    first = -1; lo_rd = 0; oe_hi = 0;
    data_in = 16'hCAFE;
    drive(1, 1, 0, HPI_DATA, 16'h0);
    for (c = 0; c < 20 && first < 0; c++) begin
      @(negedge clk);
      if (!otg_rd_n) lo_rd++;
      if (otg_data_oe) oe_hi++;
      if (!waitrequest) first = c;
      next_cycle();
    end
    drive(0, 0, 0, 2'd0, 16'h0);
    chk("rd2_done", first, 8);
    chk("rd2_rd_low", lo_rd, 4);
    chk("rd2_oe", oe_hi, 0);
    chk("rd2_rdata", readdata, 16'hCAFE);
    next_cycle();

    // extreme phase lengths on the second instance
    first = -1; lo_cs = 0; lo_wr = 0; first_wr = -1; last_wr = -1;
    address = HPI_ADDR; writedata = 16'h9999;
    cs2 = 1; wr2 = 1;
    for (c = 0; c < 40 && first < 0; c++) begin
      @(negedge clk);
      if (!cs_n2) lo_cs++;
      if (!wr_n2) begin
        lo_wr++;
        if (first_wr < 0) first_wr = c;
        last_wr = c;
      end
      if (!wait2) first = c;
      next_cycle();
    end
    cs2 = 0; wr2 = 0;
    chk("p2_done", first, 32);
    chk("p2_cs_low", lo_cs, 31);
    chk("p2_strobe", lo_wr, 1);
    chk("p2_setup", first_wr - 1, 15);
    chk("p2_hold", first - last_wr - 1, 15);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
